// File: rtl/uart_pkg.sv
// Shared UART types, parity-mode constants and the parity helper used by the rx path.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Expected parity bit for up to 9 data bits; callers zero-extend narrower words.
    function automatic logic parity_calc(input logic [8:0] data, input logic [1:0] mode);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, false-start rejection, and
// parity/framing/overrun reporting on a valid/ready word output.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int               DIV_W    = $clog2(CLKS_PER_BIT);
    localparam int               CNT_W    = 4;
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS - 1);
    localparam logic [1:0]       PAR_MODE = 2'(PARITY);

    logic                 rx_s;
    logic                 rx_prev;
    state_t               state, state_n;
    logic [DIV_W-1:0]     div, div_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bad, par_bad_n;
    logic                 frame_bad, frame_bad_n;
    logic                 done, done_n;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Receiver state, divider, bit counter, shifter and error latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div       <= '0;
            cnt       <= '0;
            shreg     <= '0;
            par_bad   <= 1'b0;
            frame_bad <= 1'b0;
            done      <= 1'b0;
            rx_prev   <= 1'b1;
        end else begin
            state     <= state_n;
            div       <= div_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            par_bad   <= par_bad_n;
            frame_bad <= frame_bad_n;
            done      <= done_n;
            rx_prev   <= rx_s;
        end
    end

    // Next-state logic; every sample point also wraps the divider to zero.
    always_comb begin
        state_n     = state;
        div_n       = div;
        cnt_n       = cnt;
        shreg_n     = shreg;
        par_bad_n   = par_bad;
        frame_bad_n = frame_bad;
        done_n      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n     = S_START;
                    div_n       = '0;
                    cnt_n       = '0;
                    par_bad_n   = 1'b0;
                    frame_bad_n = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (div == DIV_HALF) begin
                    div_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (div == DIV_LAST) begin
                    div_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (cnt == DATA_END) begin
                        cnt_n   = '0;
                        state_n = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            S_PARITY: begin
                if (div == DIV_LAST) begin
                    div_n     = '0;
                    par_bad_n = (rx_s != parity_calc(9'(shreg), PAR_MODE));
                    state_n   = S_STOP;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (div == DIV_LAST) begin
                    div_n       = '0;
                    frame_bad_n = frame_bad | ~rx_s;
                    if (cnt == STOP_END) begin
                        cnt_n   = '0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output word register, handshake and single-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= (state_n != S_IDLE);
            if (done) begin
                parity_err <= par_bad;
                frame_err  <= frame_bad;
                // A pending unaccepted word wins; the new one is dropped.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: 8N1, 8E1 and a 9-bit/2-stop/4-clk instance.
module tb_uart_rx_param;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       oe;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx0, rx1, rx2;
    logic       rdy0, rdy1, rdy2;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, oe0, oe1, oe2, b0, b1, b2;
    logic       pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
    logic       pr0 = 1'b0, pr1 = 1'b0, pr2 = 1'b0;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[3][$];

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun_err(oe0), .busy(b0));

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun_err(oe1), .busy(b1));

    uart_rx_param #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx2), .rx_data(d2), .rx_valid(v2), .rx_ready(rdy2),
        .parity_err(pe2), .frame_err(fe2), .overrun_err(oe2), .busy(b2));

    task automatic mon(input int id, input logic [8:0] d, input logic v, input logic pv,
                       input logic prdy, input logic pe, input logic fe, input logic oe);
        exp_t e;
        if ((v && !pv) || oe) begin
            n_vec++;
            assert (q[id].size() > 0) else begin
                n_bad++;
                $error("FAIL sb_empty%0d: got data=%h pe=%b fe=%b oe=%b, required no output",
                       id, d, pe, fe, oe);
            end
            if (q[id].size() > 0) begin
                e = q[id].pop_front();
                n_vec++;
                assert ({d, pe, fe, oe} === e) else begin
                    n_bad++;
                    $error("FAIL sb_word%0d: got data=%h pe=%b fe=%b oe=%b, required data=%h pe=%b fe=%b oe=%b",
                           id, d, pe, fe, oe, e.data, e.pe, e.fe, e.oe);
                end
            end
        end else if (pe || fe || (pv && v && prdy)) begin
            n_bad++;
            $error("FAIL stray%0d: pe=%b fe=%b valid=%b (prev valid=%b ready=%b), required no event",
                   id, pe, fe, v, pv, prdy);
        end
    endtask

    always @(negedge clk) begin
        mon(0, {1'b0, d0}, v0, pv0, pr0, pe0, fe0, oe0);
        mon(1, {1'b0, d1}, v1, pv1, pr1, pe1, fe1, oe1);
        mon(2, d2,         v2, pv2, pr2, pe2, fe2, oe2);
        pv0 = v0; pv1 = v1; pv2 = v2;
        pr0 = rdy0; pr1 = rdy1; pr2 = rdy2;
    end

    task automatic line(input int id, input logic b, input int n);
        case (id)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
        repeat (n) @(negedge clk);
    endtask

    // par < 0 means no parity bit; stop0 is the value of the first stop bit.
    task automatic send(input int id, input logic [8:0] data, input int nbits,
                        input int par, input logic stop0);
        int cpb;
        int nstop;
        cpb   = (id == 2) ? 4 : 16;
        nstop = (id == 2) ? 2 : 1;
        line(id, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) line(id, data[i], cpb);
        if (par >= 0) line(id, par[0], cpb);
        for (int i = 0; i < nstop; i++) line(id, (i == 0) ? stop0 : 1'b1, cpb);
        line(id, 1'b1, 2 * cpb);
    endtask

    task automatic push(input int id, input logic [8:0] data, input logic pe,
                        input logic fe, input logic oe);
        exp_t e;
        e.data = data; e.pe = pe; e.fe = fe; e.oe = oe;
        q[id].push_back(e);
    endtask

    task automatic drain(input int id);
        int t;
        t = 0;
        while (q[id].size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        assert (q[id].size() === 0) else begin
            n_bad++;
            $error("FAIL drain%0d: pending=%0d required=0", id, q[id].size());
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] req);
        n_vec++;
        assert (got === req) else begin
            n_bad++;
            $error("FAIL %s: got %h required %h", tag, got, req);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_u0", {5'd0, d0, v0, pe0, fe0, oe0, b0}, 16'h0000);
        check("reset_u2", {2'd0, d2, v2, pe2, fe2, oe2, b2}, 16'h0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean frame, then busy must be back low.
        push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, -1, 1'b1);
        drain(0);
        check("busy_after_frame", {15'd0, b0}, 16'h0000);

        // Short low glitch is rejected, next frame arrives intact.
        line(0, 1'b0, 6);
        line(0, 1'b1, 32);
        check("busy_after_glitch", {15'd0, b0}, 16'h0000);
        push(0, 9'h03C, 1'b0, 1'b0, 1'b0);
        send(0, 9'h03C, 8, -1, 1'b1);
        drain(0);

        // Even parity: 0x07 has odd weight so the correct parity bit is 1.
        push(1, 9'h007, 1'b1, 1'b0, 1'b0);
        send(1, 9'h007, 8, 0, 1'b1);
        push(1, 9'h007, 1'b0, 1'b0, 1'b0);
        send(1, 9'h007, 8, 1, 1'b1);
        drain(1);

        // Bad stop bit still delivers the word; next frame is clean.
        push(0, 9'h081, 1'b0, 1'b1, 1'b0);
        send(0, 9'h081, 8, -1, 1'b0);
        push(0, 9'h055, 1'b0, 1'b0, 1'b0);
        send(0, 9'h055, 8, -1, 1'b1);
        drain(0);

        // Break: one all-zero word with a framing error, no re-arm while low.
        push(0, 9'h000, 1'b0, 1'b1, 1'b0);
        line(0, 1'b0, 16 * 20);
        line(0, 1'b1, 32);
        drain(0);
        check("busy_after_break", {15'd0, b0}, 16'h0000);

        // Overrun: second word dropped while the first is still held.
        rdy0 = 1'b0;
        push(0, 9'h011, 1'b0, 1'b0, 1'b0);
        send(0, 9'h011, 8, -1, 1'b1);
        drain(0);
        push(0, 9'h011, 1'b0, 1'b0, 1'b1);
        send(0, 9'h022, 8, -1, 1'b1);
        drain(0);
        check("overrun_hold", {7'd0, v0, d0}, 16'h0111);
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", {15'd0, v0}, 16'h0000);
        @(negedge clk);

        // Reset in the middle of the data bits of 0xF0.
        line(0, 1'b0, 16);
        line(0, 1'b0, 16 * 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid", {5'd0, d0, v0, pe0, fe0, oe0, b0}, 16'h0000);
        line(0, 1'b1, 4);
        rst_n = 1'b1;
        line(0, 1'b1, 32);
        push(0, 9'h00F, 1'b0, 1'b0, 1'b0);
        send(0, 9'h00F, 8, -1, 1'b1);
        drain(0);

        // 9 data bits, 2 stop bits, 4 clocks per bit.
        push(2, 9'h1A5, 1'b0, 1'b0, 1'b0);
        send(2, 9'h1A5, 9, -1, 1'b1);
        push(2, 9'h0C3, 1'b0, 1'b1, 1'b0);
        send(2, 9'h0C3, 9, -1, 1'b0);
        push(2, 9'h13C, 1'b0, 1'b0, 1'b0);
        send(2, 9'h13C, 9, -1, 1'b1);
        drain(2);
        check("busy_u2", {15'd0, b2}, 16'h0000);

        repeat (8) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
